// File: rtl/sr_pkg.sv
// sr_pkg: shared constants and helpers for the sr_bank set/reset register bank.
//   MODE_*     - S=R=1 resolution modes for a channel.
//   cnt_width  - width of a lockout counter able to hold the value 'lockout'.
package sr_pkg;

    localparam int unsigned MODE_HOLD    = 0;
    localparam int unsigned MODE_SET_DOM = 1;
    localparam int unsigned MODE_RST_DOM = 2;

    // At least one bit so a zero-length lockout still yields a legal vector type.
    function automatic int unsigned cnt_width(input int unsigned lockout);
        return (lockout == 0) ? 1 : $clog2(lockout + 1);
    endfunction

endpackage

// File: rtl/sr_bank_if.sv
// sr_bank_if: bundle of the per-channel request and status signals of sr_bank.
//   s, r    - per-channel set / reset request levels (master -> slave)
//   clear   - synchronous global clear (master -> slave)
//   q       - registered channel state (slave -> master)
//   q_rise  - one-cycle pulse on q 0->1 (slave -> master)
//   q_fall  - one-cycle pulse on q 1->0 (slave -> master)
//   locked  - channel is in post-trip lockout (slave -> master)
interface sr_bank_if #(
    parameter int unsigned CHANNELS = 4
);

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] r;
    logic                clear;
    logic [CHANNELS-1:0] q;
    logic [CHANNELS-1:0] q_rise;
    logic [CHANNELS-1:0] q_fall;
    logic [CHANNELS-1:0] locked;

    modport master (
        output s, r, clear,
        input  q, q_rise, q_fall, locked
    );

    modport slave (
        input  s, r, clear,
        output q, q_rise, q_fall, locked
    );

endinterface

// File: rtl/sr_channel.sv
// sr_channel: one set/reset channel of sr_bank.
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   s, r       - set / reset request levels, synchronised through SYNC_STAGES flops
//   clear      - synchronous clear, used directly (highest priority)
//   q          - registered channel state
//   q_rise     - one-cycle pulse registered with q 0->1
//   q_fall     - one-cycle pulse registered with q 1->0
//   locked     - high while the re-arm lockout counter is non-zero
module sr_channel
    import sr_pkg::*;
#(
    parameter int unsigned MODE        = MODE_HOLD,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCKOUT     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    input  logic clear,
    output logic q,
    output logic q_rise,
    output logic q_fall,
    output logic locked
);

    logic ss;
    logic rs;
    logic lock_active;
    logic q_q, q_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Input synchroniser
    if (SYNC_STAGES == 0) begin : g_nosync
        assign ss = s;
        assign rs = r;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] s_sync_q;
        logic [SYNC_STAGES-1:0] r_sync_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_sync_q <= '0;
                r_sync_q <= '0;
            end else begin
                s_sync_q[0] <= s;
                r_sync_q[0] <= r;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    s_sync_q[i] <= s_sync_q[i-1];
                    r_sync_q[i] <= r_sync_q[i-1];
                end
            end
        end

        assign ss = s_sync_q[SYNC_STAGES-1];
        assign rs = r_sync_q[SYNC_STAGES-1];
    end

    // Next-state: clear, then reset, then set (gated by lockout), then conflict mode.
    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = 1'b0;
        end else begin
            case ({ss, rs})
                2'b01: q_d = 1'b0;
                2'b10: begin
                    if (!lock_active) q_d = 1'b1;
                end
                2'b11: begin
                    if (MODE == MODE_SET_DOM) begin
                        if (!lock_active) q_d = 1'b1;
                    end else if (MODE == MODE_RST_DOM) begin
                        q_d = 1'b0;
                    end
                    // MODE_HOLD and illegal modes keep the current state.
                end
                default: ;
            endcase
        end
        rise_d = ~q_q & q_d;
        fall_d = q_q & ~q_d;
    end

    // Lockout counter: loaded only by a real 1->0 transition, so r or clear on an
    // already-clear channel never (re)starts it.
    if (LOCKOUT > 0) begin : g_lock
        localparam int unsigned CntW = cnt_width(LOCKOUT);

        logic [CntW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (fall_d) begin
                cnt_d = CntW'(LOCKOUT);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign lock_active = (cnt_q != '0);
    end else begin : g_nolock
        assign lock_active = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q      = q_q;
    assign q_rise = rise_q;
    assign q_fall = fall_q;
    assign locked = lock_active;

endmodule

// File: rtl/sr_bank.sv
// sr_bank: multi-channel clocked set/reset register bank with per-channel
// input synchroniser, S=R=1 resolution mode, post-trip re-arm lockout and
// rise/fall event pulses. Gates the magnetron enable downstream.
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   bus        - sr_bank_if slave: s, r, clear in; q, q_rise, q_fall, locked out
module sr_bank
    import sr_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned MODE        = MODE_HOLD,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCKOUT     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_bank_if.slave    bus
);

    logic [CHANNELS-1:0] q_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;
    logic [CHANNELS-1:0] locked_w;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
        sr_channel #(
            .MODE        (MODE),
            .SYNC_STAGES (SYNC_STAGES),
            .LOCKOUT     (LOCKOUT)
        ) u_channel (
            .clk    (clk),
            .rst_n  (rst_n),
            .s      (bus.s[ch]),
            .r      (bus.r[ch]),
            .clear  (bus.clear),
            .q      (q_w[ch]),
            .q_rise (rise_w[ch]),
            .q_fall (fall_w[ch]),
            .locked (locked_w[ch])
        );
    end

    assign bus.q      = q_w;
    assign bus.q_rise = rise_w;
    assign bus.q_fall = fall_w;
    assign bus.locked = locked_w;

endmodule

// File: doc/sr_bank.md
Name: sr_bank

Overview:
- Parametrised, clocked multi-channel set/reset register bank; successor to the single-bit combinational SR latch.
- Each channel has an input synchroniser, a configurable S=R=1 resolution mode and a post-reset re-arm lockout.
- It also emits one-cycle rise/fall event pulses.
- Sits between the panel/door/timer control logic and the magnetron enable. The lockout stops the magnetron re-energising immediately after a trip.

Parameters:
- CHANNELS, 4, number of independent SR channels.
- MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant.
- SYNC_STAGES, 2, synchroniser flops on s/r (0 = inputs used directly).
- LOCKOUT, 8, cycles a channel ignores set after q falls (0 = no lockout).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s  input  CHANNELS  per-channel set request (level).
- r  input  CHANNELS  per-channel reset request (level).
- clear  input  1  synchronous global clear; not synchronised.
- q  output  CHANNELS  registered channel state.
- q_rise  output  CHANNELS  one-cycle pulse on q 0->1.
- q_fall  output  CHANNELS  one-cycle pulse on q 1->0.
- locked  output  CHANNELS  high while the channel's lockout counter is non-zero.

Behaviour:
- Reset (rst_n=0, asynchronous): q, q_rise, q_fall and locked go to 0 immediately. Synchroniser flops and lockout counters go to 0. Reset mid-lockout cancels the lockout.
- Synchroniser: s/r pass through SYNC_STAGES flops.
  - With SYNC_STAGES=2, a level stable across edge k updates q at edge k+2.
  - In general, q updates at edge k+SYNC_STAGES.
- Per-channel next-state, from synchronised (ss, rs):
  - Priority 1: clear=1 -> q=0.
  - Priority 2: ss=0, rs=1 -> q=0.
  - Priority 3: ss=1, rs=0 -> q=1, unless locked.
  - Priority 4: ss=1, rs=1 -> MODE 0 hold; MODE 1 set (subject to lockout); MODE 2 reset.
  - Priority 5: ss=0, rs=0 -> hold.
- Lockout: on any edge where q goes 1->0 (r, MODE 2 conflict, or clear), the counter loads LOCKOUT and locked=1 from that same edge.
  - The counter decrements on each subsequent edge. locked drops at the edge where it reaches 0.
  - A set is accepted on the first edge where locked is already 0, i.e. q rises LOCKOUT+1 edges after the falling edge if set is held.
  - Set requests during lockout are dropped, not queued. A held level is re-evaluated each cycle.
  - Reset requests during lockout: q is already 0, no effect, counter is not reloaded.
  - A q already at 0 receiving r or clear does not start a lockout.
- Counter width: $clog2(LOCKOUT+1), minimum 1. With LOCKOUT=0, locked is tied to 0.
- q_rise/q_fall are registered at the same edge q changes and are high for exactly one cycle. They are never both high.
- Channels are fully independent apart from the shared clear.
- Illegal MODE (>2) behaves as MODE 0; the bench flags it with an elaboration assertion.

Decomposition:
- Shared package sr_pkg: MODE_HOLD=0, MODE_SET_DOM=1, MODE_RST_DOM=2, and a counter-width function.
- Sub-module sr_channel: one channel's synchroniser, next-state logic, lockout counter and edge pulses. sr_bank instantiates it CHANNELS times in a generate loop and broadcasts clear.

Test Plan:
1. CHANNELS=4, SYNC_STAGES=2, LOCKOUT=8, MODE=0. Hold rst_n=0 with s=4'hF -> all outputs 0. Release, then pulse s[0] across edge k -> q[0]=1 at edge k+2, q_rise[0] high one cycle, other channels 0.
2. With q[0]=1, pulse r[0] -> q[0]=0 and q_fall[0] one cycle; locked[0]=1 for 8 cycles. Hold s[0]=1 from the next cycle -> q[0] rises exactly 9 edges after the falling edge.
3. Apply s[1]=r[1]=1 with q[1]=0, then with q[1]=1, in each MODE:
   - MODE 0 -> q[1] held in both cases.
   - MODE 1 -> q[1]=1.
   - MODE 2 -> q[1]=0, with lockout if it was 1.
4. q=4'hF, s[2]=1 held, assert clear one cycle -> q=4'h0 next edge, q_fall=4'hF one cycle, locked=4'hF. s[2] is ignored until the lockout expires.
5. Assert rst_n=0 asynchronously mid-lockout (counter=3) -> q and locked drop with no clock edge. After release, s[0] sets q[0] at normal 2-edge latency.
6. SYNC_STAGES=0, LOCKOUT=0. Pulse s[3] -> q[3]=1 next edge. Then r[3] and s[3] on consecutive cycles -> q[3] goes 1,0,1 with no lockout and locked stays 0.
